// File: rtl/scs_decoder_if.sv
// ---------------------------------------------------------------------------
// scs_decoder_if -- flit handshake bundle for the SCS decoder.
//   in_valid / in_ready / in_flit[31:0]   : encoded flit stream into the decoder
//   out_valid / out_ready                 : decoded stream handshake
//   out_data[30:0] / out_inv              : decoded payload and its invert flag
// master : the side that sources flits and sinks decoded data (e.g. a bench)
// slave  : the decoder itself
// ---------------------------------------------------------------------------
interface scs_decoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_flit;
  logic        out_valid;
  logic        out_ready;
  logic [30:0] out_data;
  logic        out_inv;

  modport master (
    output in_valid, in_flit, out_ready,
    input  in_ready, out_valid, out_data, out_inv
  );

  modport slave (
    input  in_valid, in_flit, out_ready,
    output in_ready, out_valid, out_data, out_inv
  );
endinterface

// File: rtl/scs_decoder.sv
// ---------------------------------------------------------------------------
// scs_decoder -- decodes bus-invert-coded flits into a first-word
// fall-through FIFO and keeps saturating flit statistics.
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   bus        : scs_decoder_if.slave (flit in / decoded payload out)
//   clr_stats  : synchronous clear of both counters
//   flit_count : flits accepted since reset/clear (saturating)
//   inv_count  : accepted flits whose invert flag was set (saturating)
// Each FIFO entry stores {invert flag, decoded payload}; decode happens at
// write time so the read side is a plain storage lookup.
// ---------------------------------------------------------------------------
module scs_decoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  scs_decoder_if.slave       bus,
  input  logic               clr_stats,
  output logic [CNT_W-1:0]   flit_count,
  output logic [CNT_W-1:0]   inv_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0]      r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [CNT_W-1:0] r_flit_cnt;
  logic [CNT_W-1:0] r_inv_cnt;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_head;
  logic [30:0] w_decoded;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty = (r_wptr == r_rptr);

  // in_ready deliberately ignores a same-cycle pop: no write when full.
  assign bus.in_ready  = !w_full && !rst;
  assign bus.out_valid = !w_empty;

  assign w_push = bus.in_valid && bus.in_ready;
  assign w_pop  = bus.out_valid && bus.out_ready;

  assign w_decoded = bus.in_flit[30:0] ^ {31{bus.in_flit[31]}};

  // Head is read straight from storage; forced to zero when nothing is held
  // so stale entries never leak onto the output.
  assign w_head       = r_mem[r_rptr[AW-1:0]];
  assign bus.out_data = w_empty ? 31'd0 : w_head[30:0];
  assign bus.out_inv  = w_empty ? 1'b0  : w_head[31];

  assign flit_count = r_flit_cnt;
  assign inv_count  = r_inv_cnt;

  // Storage has no reset: discarding is done by resetting the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= {bus.in_flit[31], w_decoded};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Clear beats a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      r_flit_cnt <= '0;
      r_inv_cnt  <= '0;
    end else if (w_push) begin
      if (r_flit_cnt != CNT_MAX) r_flit_cnt <= r_flit_cnt + 1'b1;
      if (bus.in_flit[31] && (r_inv_cnt != CNT_MAX)) r_inv_cnt <= r_inv_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_scs_decoder.sv
// ---------------------------------------------------------------------------
// tb_scs_decoder -- directed bench for scs_decoder (DEPTH=4, CNT_W=4).
// A negedge monitor keeps a queue of expected {inv, payload} entries,
// pushed on accepted flits and popped/compared on each consumed head.
// ---------------------------------------------------------------------------
module tb_scs_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_stats;
  logic [3:0] flit_count;
  logic [3:0] inv_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] sb_q[$];

  scs_decoder_if bus ();

  scs_decoder #(.DEPTH(4), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .clr_stats  (clr_stats),
    .flit_count (flit_count),
    .inv_count  (inv_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] f);
    return {f[31], f[30:0] ^ {31{f[31]}}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: sampled mid-cycle, reflecting the handshakes of the next edge.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_head = '0;
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (!bus.out_valid) begin
        chk("idle_zero", {32'd0, bus.out_inv, bus.out_data}, 64'd0);
      end
      if (prev_hold) begin
        chk("hold_stable", {32'd0, bus.out_inv, bus.out_data}, {32'd0, prev_head});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          chk("pop_data", {32'd0, bus.out_inv, bus.out_data}, {32'd0, sb_q.pop_front()});
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb_q.push_back(model(bus.in_flit));
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_head = {bus.out_inv, bus.out_data};
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    clr_stats    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_flit  = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    // Reset state
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_counts", {56'd0, flit_count, inv_count}, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Basic decode with out_ready=1
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_flit   = 32'h1234_5678;
    step();
    chk("lat_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("dec_plain", {32'd0, bus.out_inv, bus.out_data}, {32'd0, 1'b0, 31'h1234_5678});
    bus.in_flit = 32'h9234_5678;
    step();
    chk("dec_inv", {32'd0, bus.out_inv, bus.out_data}, {32'd0, 1'b1, 31'h6DCB_A987});
    bus.in_valid = 1'b0;
    step();
    chk("cnt_after_two", {56'd0, flit_count, inv_count}, {56'd0, 4'd2, 4'd1});
    chk("empty_after_two", {63'd0, bus.out_valid}, 64'd0);

    // Boundary payloads
    bus.in_valid = 1'b1;
    bus.in_flit  = 32'h8000_0000;
    step();
    chk("dec_8000", {32'd0, bus.out_inv, bus.out_data}, {32'd0, 1'b1, 31'h7FFF_FFFF});
    bus.in_flit = 32'h7FFF_FFFF;
    step();
    chk("dec_7fff", {32'd0, bus.out_inv, bus.out_data}, {32'd0, 1'b0, 31'h7FFF_FFFF});
    bus.in_valid = 1'b0;
    step();

    // Fill with out_ready=0, then drain
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_flit  = 32'hA000_0010 ^ (32'(i) << 28) ^ 32'(i);
      chk($sformatf("fill_ready_%0d", i), {63'd0, bus.in_ready}, (i < 4) ? 64'd1 : 64'd0);
      step();
    end
    bus.in_valid = 1'b0;
    chk("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("full_count", {60'd0, flit_count}, 64'd8);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_valid_%0d", i), {63'd0, bus.out_valid}, 64'd1);
      step();
    end
    chk("drained_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("drained_data", {33'd0, bus.out_data}, 64'd0);
    chk("drained_sb", 64'(sb_q.size()), 64'd0);

    // Steady occupancy of 2 across pointer wrap
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_flit   = 32'h0000_0101;
    step();
    bus.in_flit   = 32'h8000_0202;
    step();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_flit = {i[0], 7'd0, 8'(i), 16'h5A5A};
      chk($sformatf("wrap_ready_%0d", i), {62'd0, bus.in_ready, bus.out_valid}, 64'd3);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    chk("wrap_tail1", {63'd0, bus.out_valid}, 64'd1);
    step();
    chk("wrap_tail0", {63'd0, bus.out_valid}, 64'd0);

    // Counter saturation and clear priority
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    chk("clr_counts", {56'd0, flit_count, inv_count}, 64'd0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.in_flit = 32'hC000_0000 | 32'(i);
      step();
      if (i == 13) chk("cnt_14", {56'd0, flit_count, inv_count}, {56'd0, 4'd14, 4'd14});
    end
    chk("cnt_sat", {56'd0, flit_count, inv_count}, {56'd0, 4'd15, 4'd15});
    clr_stats   = 1'b1;
    bus.in_flit = 32'h8000_0001;
    step();
    clr_stats    = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_vs_push", {56'd0, flit_count, inv_count}, 64'd0);
    step();
    chk("clr_fifo_kept", 64'(sb_q.size()), 64'd0);

    // Reset mid-operation
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_flit = 32'h0F00_0000 | 32'(i);
      step();
    end
    bus.in_valid = 1'b0;
    chk("pre_rst_count", {60'd0, flit_count}, 64'd3);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("mid_rst_counts", {56'd0, flit_count, inv_count}, 64'd0);
    chk("mid_rst_ready", {63'd0, bus.in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    chk("after_rst_ready", {63'd0, bus.in_ready}, 64'd1);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_flit   = 32'h8ABC_DEF0;
    step();
    bus.in_valid = 1'b0;
    chk("after_rst_first", {31'd0, bus.out_valid, bus.out_inv, bus.out_data},
        {31'd0, 1'b1, 1'b1, 31'h0ABC_DEF0 ^ 31'h7FFF_FFFF});
    step();
    chk("after_rst_alone", {63'd0, bus.out_valid}, 64'd0);
    chk("final_sb", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scs_decoder.md
SCS_DECODER -- requirements
Module: scs_decoder

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; SHALL be a power of two, at least 2.
REQ-002 Parameter CNT_W, default 16, width of the statistics counters.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; SHALL be synchronous and active-high.
REQ-005 in_valid  input  1  encoded flit present on in_flit.
REQ-006 in_ready  output  1  decoder can accept a flit this cycle.
REQ-007 in_flit  input  32  encoded flit: bit 31 = invert flag, bits 30:0 = payload (possibly inverted).
REQ-008 out_valid  output  1  decoded payload present at FIFO head.
REQ-009 out_ready  input  1  consumer accepts the head this cycle.
REQ-010 out_data  output  31  decoded payload.
REQ-011 out_inv  output  1  invert flag that arrived with the head flit.
REQ-012 clr_stats  input  1  synchronous clear of both counters.
REQ-013 flit_count  output  CNT_W  flits accepted since reset/clear.
REQ-014 inv_count  output  CNT_W  accepted flits with bit 31 set.

Function
REQ-015 Decode SHALL be out_data = in_flit[30:0] XOR {31{in_flit[31]}}, computed at write time, so the stored entry is {in_flit[31], decoded payload}.
REQ-016 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-017 in_ready SHALL equal !full && !rst; there is no write when full, even if a pop happens in the same cycle.
REQ-018 out_valid SHALL equal !empty; out_data/out_inv SHALL be driven from registered storage at the read pointer (first-word fall-through), with no combinational input-to-output bypass.
REQ-019 Latency: a flit pushed at edge N SHALL appear on out_valid/out_data in the cycle after edge N.
REQ-020 Simultaneous push and pop when non-empty and non-full SHALL leave occupancy unchanged and preserve order.
REQ-021 Pointers SHALL be log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH. full = MSBs differ and LSBs equal; empty = pointers equal.
REQ-022 While out_valid is 0, out_data SHALL be 0 and out_inv SHALL be 0.
REQ-023 While out_valid=1 and out_ready=0, out_data/out_inv SHALL hold stable.
REQ-024 flit_count SHALL increment on each push; inv_count SHALL increment on each push with in_flit[31]=1.
REQ-025 Both counters SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-026 clr_stats=1 SHALL zero both counters at the next edge; clear SHALL take priority over a same-cycle increment; the FIFO SHALL be unaffected.

Reset
REQ-027 With rst=1 at an edge: pointers, flit_count and inv_count SHALL go to 0, and out_valid=0, out_data=0, out_inv=0.
REQ-028 in_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst deasserts.
REQ-029 rst asserted mid-traffic SHALL discard all stored flits; storage contents need not be cleared.
REQ-030 rst SHALL have priority over push, pop and clr_stats.

Verification
REQ-031 Push 0x1234_5678 then 0x9234_5678 with out_ready=1:
- out_data = 0x1234_5678 with out_inv=0.
- then out_data = 0x6DCB_A987 with out_inv=1.
- flit_count=2, inv_count=1.
REQ-032 Push 0x8000_0000 → out_data = 0x7FFF_FFFF, out_inv=1. Push 0x7FFF_FFFF → out_data = 0x7FFF_FFFF, out_inv=0.
REQ-033 Fill and drain with out_ready=0:
- push 5 flits back-to-back (DEPTH=4);
- in_ready=0 after the 4th push, and the 5th is not accepted;
- raise out_ready, 4 entries drain in order, then out_valid=0 and out_data=0.
REQ-034 Pointer wrap and order:
- keep occupancy at 2 with push+pop every cycle for 20 cycles;
- ordering preserved across pointer wrap, and occupancy constant.
REQ-035 Counters with CNT_W=4:
- push 17 inverted flits → both counters saturate at 15;
- clr_stats together with a push → both counters read 0 the next cycle.
REQ-036 Reset mid-operation:
- assert rst with 3 entries stored → next cycle out_valid=0, counters 0, in_ready=0;
- after deassert, in_ready=1 and the first new push emerges alone.
